// File: rtl/adder.sv
// rtl/adder.sv - ADD instruction encoder with a single valid/ready output register stage
module adder #(
    parameter logic [4:0] OPC_ADD_REG = 5'b00001,
    parameter logic [4:0] OPC_ADD_IMM = 5'b00010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        imm_sel,
    input  logic [3:0]  rsd,
    input  logic [3:0]  rsn,
    input  logic [7:0]  rsm,
    output logic [20:0] instruction,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err
);

    logic [4:0]  opcode;
    logic [7:0]  operand;
    logic [20:0] word_next;
    logic        err_next;
    logic        accept;

    always_comb begin
        opcode    = imm_sel ? OPC_ADD_IMM : OPC_ADD_REG;
        operand   = imm_sel ? rsm : {4'b0000, rsm[3:0]};
        word_next = {opcode, rsd, rsn, operand};
        // register mode drops the upper nibble; flag it rather than refuse the word
        err_next  = !imm_sel && (rsm[7:4] != 4'b0000);
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            instruction <= 21'd0;
            out_valid   <= 1'b0;
            err         <= 1'b0;
        end else if (accept) begin
            instruction <= word_next;
            out_valid   <= 1'b1;
            err         <= err_next;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder.sv
// tb/tb_adder.sv - directed scoreboard bench for the ADD instruction encoder
module tb_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        imm_sel;
    logic [3:0]  rsd;
    logic [3:0]  rsn;
    logic [7:0]  rsm;
    logic [20:0] instruction;
    logic        out_valid;
    logic        out_ready;
    logic        err;

    typedef struct {
        logic [20:0] instr;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic        m_valid;
    logic [20:0] m_last;
    bit          m_known;
    int          vectors;
    int          miscompares;

    adder dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .imm_sel(imm_sel),
        .rsd(rsd),
        .rsn(rsn),
        .rsm(rsm),
        .instruction(instruction),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit iv, input bit is, input logic [3:0] d,
                        input logic [3:0] n, input logic [7:0] m, input bit ordy);
        exp_t e;
        bit   acc;
        rst       = r;
        in_valid  = iv;
        imm_sel   = is;
        rsd       = d;
        rsn       = n;
        rsm       = m;
        out_ready = ordy;
        #1;
        if (m_known) check("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || ordy)});
        if (!r) begin
            exp_q.delete();
            m_valid = 1'b0;
            m_last  = 21'd0;
            m_known = 1'b1;
        end else begin
            acc = iv && (!m_valid || ordy);
            if (m_valid && ordy) void'(exp_q.pop_front());
            if (acc) begin
                e.instr = is ? {5'b00010, d, n, m} : {5'b00001, d, n, 4'h0, m[3:0]};
                e.err   = !is && (m[7:4] != 4'h0);
                exp_q.push_back(e);
                m_last  = e.instr;
            end
            m_valid = acc ? 1'b1 : (ordy ? 1'b0 : m_valid);
        end
        @(posedge clk);
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid && exp_q.size() > 0) begin
            check("instruction", {11'd0, instruction}, {11'd0, exp_q[0].instr});
            check("err", {31'd0, err}, {31'd0, exp_q[0].err});
        end else begin
            check("instruction_idle", {11'd0, instruction}, {11'd0, m_last});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_valid     = 1'b0;
        m_last      = 21'd0;
        m_known     = 1'b0;
        rst = 1'b0; in_valid = 1'b0; imm_sel = 1'b0;
        rsd = 4'h0; rsn = 4'h0; rsm = 8'h00; out_ready = 1'b0;

        step(0, 0, 0, 4'h0, 4'h0, 8'h00, 0);
        step(0, 0, 0, 4'h0, 4'h0, 8'h00, 0);
        step(1, 0, 0, 4'h0, 4'h0, 8'h00, 0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        step(1, 1, 0, 4'b0100, 4'b0101, 8'h03, 1);
        check("reg_add_word", {11'd0, instruction}, {11'd0, 21'b00001_0100_0101_00000011});
        check("reg_add_opcode", {27'd0, instruction[20:16]}, 32'd1);

        step(1, 1, 1, 4'b0001, 4'b0010, 8'hA5, 1);
        check("imm_add_word", {11'd0, instruction}, {11'd0, 21'b00010_0001_0010_10100101});

        step(1, 1, 0, 4'b0111, 4'b1000, 8'h39, 1);
        check("bad_nibble_word", {11'd0, instruction}, {11'd0, 21'b00001_0111_1000_00001001});
        check("bad_nibble_err", {31'd0, err}, 32'd1);

        for (int i = 0; i < 3; i++)
            step(1, 1, i[0], 4'hF - 4'(i), 4'(i), 8'hC0 + 8'(i), 0);
        check("hold_word", {11'd0, instruction}, {11'd0, 21'b00001_0111_1000_00001001});
        check("hold_in_ready", {31'd0, in_ready}, 32'd0);

        step(1, 0, 0, 4'h0, 4'h0, 8'h00, 1);
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 4; i++)
            step(1, 1, 1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 8'($urandom), 1);
        check("stream_valid", {31'd0, out_valid}, 32'd1);

        step(0, 1, 1, 4'hA, 4'hB, 8'hCC, 1);
        check("mid_reset_word", {11'd0, instruction}, 32'd0);
        check("mid_reset_valid", {31'd0, out_valid}, 32'd0);

        step(1, 0, 0, 4'h0, 4'h0, 8'h00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder.md
Name: adder

Overview:
- Instruction encoder for the ADD operation in the processor front end.
- Packs destination register, source register and second operand (register index or 8-bit immediate) into a 21-bit instruction word, prefixed by a 5-bit opcode.
- The result is registered and passed downstream through a valid/ready handshake; it feeds instruction memory or the pipeline fetch path.

Parameters:
- OPC_ADD_REG, 5'b00001, opcode emitted for register-register ADD.
- OPC_ADD_IMM, 5'b00010, opcode emitted for register-immediate ADD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- in_valid  input  1  operand fields are valid this cycle.
- in_ready  output  1  encoder can accept a new operand set.
- imm_sel  input  1  0 = rsm is a register index; 1 = rsm is an 8-bit immediate.
- rsd  input  4  destination register index.
- rsn  input  4  first source register index.
- rsm  input  8  second source: register index in [3:0], or immediate.
- instruction  output  21  encoded instruction word.
- out_valid  output  1  instruction holds a valid word.
- out_ready  input  1  downstream accepts instruction this cycle.
- err  output  1  qualifies instruction; set when a register-mode word had a non-zero rsm[7:4].

Behaviour:
- Field layout:
  - [20:16] opcode
  - [15:12] rsd
  - [11:8] rsn
  - [7:0] operand
- Opcode selection: imm_sel=0 gives OPC_ADD_REG; imm_sel=1 gives OPC_ADD_IMM.
- Operand field:
  - Immediate mode: rsm unchanged.
  - Register mode: {4'b0000, rsm[3:0]}, with rsm[7:4] discarded.
- err is registered alongside the word: err=1 iff imm_sel=0 and rsm[7:4]!=0.
  - The word is still emitted, with the zero-extended operand.
  - err is meaningful only while out_valid=1.
- Reset (rst=0 at a clk edge): instruction=0, out_valid=0, err=0.
  - in_ready is combinational, so it reads 1 after reset.
  - Reset overrides any simultaneous load or handshake.
  - Reset mid-transfer discards the pending word.
- in_ready = !out_valid || out_ready (combinational).
- Accept: in_valid && in_ready at a clk edge. The encoded word, out_valid=1 and err load on that edge, so latency is 1 cycle.
- Hold: out_valid && !out_ready. instruction, err and out_valid stay stable; in_ready=0; inputs are ignored.
- Drain: out_ready=1 with no accept clears out_valid. instruction keeps its last value.
- Simultaneous drain and accept: the new word replaces the old one in the same edge, out_valid stays 1. This gives full throughput of one word per cycle.
- Inputs are sampled only on an accepting edge; changes between accepts have no effect.
- Purely combinational packing feeding a single register stage. No arithmetic is performed and no overflow is possible.

Test Plan:
- Reset: rst=0 for 2 cycles, then rst=1 -> instruction=21'h0, out_valid=0, err=0, in_ready=1.
- Register ADD: imm_sel=0, rsd=4'b0100, rsn=4'b0101, rsm=8'h03, in_valid=1, out_ready=1 -> next cycle instruction=21'b00001_0100_0101_00000011, instruction[20:16]=5'b00001, out_valid=1, err=0.
- Immediate ADD: imm_sel=1, rsd=4'b0001, rsn=4'b0010, rsm=8'hA5 -> instruction=21'b00010_0001_0010_10100101, err=0.
- Register mode with a bad upper nibble: imm_sel=0, rsd=4'b0111, rsn=4'b1000, rsm=8'h39 -> instruction=21'b00001_0111_1000_00001001, err=1.
- Backpressure: with out_valid=1, hold out_ready=0 for 3 cycles while changing the inputs -> instruction unchanged, in_ready=0. Then out_ready=1 with no in_valid -> out_valid drops after 1 edge.
- Streaming and reset: in_valid=1 and out_ready=1 over 4 consecutive words -> a new word each cycle, out_valid stays 1. Then assert rst=0 alongside in_valid=1 -> out_valid=0, instruction=0 after that edge.
